// File: rtl/rx_preamble_strip.sv
// rx_preamble_strip: checks and strips 0x5 preamble and 0xD SFD from a PHY nibble stream, forwarding only the frame body
module rx_preamble_strip #(
    parameter int MIN_PREAMBLE = 4,
    parameter int MAX_PREAMBLE = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_v,
    input  logic [3:0] i_d,
    output logic       o_v,
    output logic [3:0] o_d,
    output logic       o_err
);
    typedef enum logic [2:0] {IDLE, PRE, DATA, PASS, DROP} state_t;
    state_t state, state_n;
    logic [4:0] count, count_n;
    logic v_n, err_n;
    logic [3:0] d_n;
    always_comb begin
        state_n = state;
        count_n = count;
        v_n = 1'b0;
        d_n = 4'd0;
        err_n = 1'b0;
        case (state)
            IDLE:
                if (i_v) begin
                    if (!i_en) begin
                        state_n = PASS;
                        v_n = 1'b1;
                        d_n = i_d;
                    end else if (i_d == 4'h5) begin
                        state_n = PRE;
                        count_n = 5'd1;
                    end else begin
                        state_n = DROP;
                        err_n = 1'b1;
                    end
                end
            PRE:
                if (!i_v) begin
                    state_n = IDLE;
                    err_n = 1'b1;
                end else if (i_d == 4'h5 && count < 5'(MAX_PREAMBLE)) begin
                    count_n = count + 5'd1;
                end else if (i_d == 4'hD && count >= 5'(MIN_PREAMBLE)) begin
                    state_n = DATA;
                end else begin
                    state_n = DROP;
                    err_n = 1'b1;
                end
            DATA, PASS: begin
                v_n = i_v;
                d_n = i_v ? i_d : 4'd0;
                state_n = i_v ? state : IDLE;
            end
            DROP: state_n = i_v ? DROP : IDLE;
            default: state_n = DROP;
        endcase
    end
    // Reset lands in DROP so a packet already on the wire is ignored until its i_v gap
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= DROP;
            count <= 5'd0;
            o_v <= 1'b0;
            o_d <= 4'd0;
            o_err <= 1'b0;
        end else if (i_ce) begin
            state <= state_n;
            count <= count_n;
            o_v <= v_n;
            o_d <= d_n;
            o_err <= err_n;
        end
    end
endmodule

// File: tb/tb_rx_preamble_strip.sv
// tb_rx_preamble_strip: randomized and directed checks of rx_preamble_strip against a prefix-based packet model
module tb_rx_preamble_strip;
    localparam int MINP = 4;
    localparam int MAXP = 15;
    typedef logic [3:0] nq_t[$];
    logic clk = 0, rst = 1, ce = 0, en = 1, v = 0;
    logic [3:0] d = 0;
    logic ov, oerr;
    logic [3:0] od;
    rx_preamble_strip #(.MIN_PREAMBLE(MINP), .MAX_PREAMBLE(MAXP)) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_en(en), .i_v(v), .i_d(d),
        .o_v(ov), .o_d(od), .o_err(oerr)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0, errs = 0;
    logic ev = 0, ee = 0;
    logic [3:0] ed = 0;
    bit started = 0, cap = 0, ign = 1, strip = 1;
    nq_t pk, outs;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("o_v", int'(ov), int'(ev));
            chk("o_d", int'(od), int'(ed));
            chk("o_err", int'(oerr), int'(ee));
            if (cap && ov) outs.push_back(od);
            if (cap && oerr) errs++;
        end
    end

    // s: index of an accepted SFD, e: index of the nibble that breaks the preamble
    function automatic void resolve(input nq_t p, output int s, output int e);
        s = -1;
        e = -1;
        for (int i = 0; i < p.size(); i++) begin
            if (p[i] == 4'h5) begin
                if (i >= MAXP) begin e = i; break; end
            end else begin
                if (p[i] == 4'hD && i >= MINP) s = i; else e = i;
                break;
            end
        end
    endfunction

    task automatic step(input bit c, input bit r, input bit vv, input bit e_, input logic [3:0] dd);
        int s, e;
        @(negedge clk);
        ce = c; rst = r; v = vv; en = e_; d = dd;
        cap = c && !r;
        started = 1;
        if (r) begin
            ev = 0; ed = 0; ee = 0; ign = 1; pk.delete();
        end else if (c) begin
            if (!vv) begin
                resolve(pk, s, e);
                ee = !ign && pk.size() > 0 && strip && s < 0 && e < 0;
                ev = 0; ed = 0; ign = 0; pk.delete();
            end else if (ign) begin
                ev = 0; ed = 0; ee = 0;
            end else begin
                if (pk.size() == 0) strip = e_;
                pk.push_back(dd);
                if (!strip) begin
                    ev = 1; ed = dd; ee = 0;
                end else begin
                    resolve(pk, s, e);
                    ev = s >= 0 && pk.size() - 1 > s;
                    ed = ev ? dd : 4'd0;
                    ee = e == pk.size() - 1;
                end
            end
        end
    endtask

    function automatic nq_t mkp(input int npre, input int sfd, input int nb, input int base);
        nq_t q;
        for (int i = 0; i < npre; i++) q.push_back(4'h5);
        if (sfd >= 0) q.push_back(4'(sfd));
        for (int i = 0; i < nb; i++) q.push_back(4'(base + i));
        return q;
    endfunction

    task automatic send(input nq_t p, input bit en0, input bit en1, input int hold);
        bit vv, e_;
        logic [3:0] dd;
        int w;
        for (int i = 0; i <= p.size(); i++) begin
            vv = i < p.size();
            dd = vv ? p[i] : 4'd0;
            e_ = i == 0 ? en0 : en1;
            w = hold < 0 ? $urandom_range(0, 2) : hold;
            repeat (w) step(0, 0, vv, e_, dd);
            step(1, 0, vv, e_, dd);
        end
    endtask

    task automatic pin(input string nm, input int n, input int base, input int ne);
        step(1, 0, 0, 1, 0);
        chk({nm, "_count"}, outs.size(), n);
        for (int i = 0; i < n; i++) chk({nm, "_data"}, i < outs.size() ? int'(outs[i]) : -1, (base + i) & 15);
        chk({nm, "_errs"}, errs, ne);
        outs.delete();
        errs = 0;
    endtask

    initial begin
        nq_t q;
        repeat (3) step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        pin("reset", 0, 0, 0);
        send(mkp(15, 13, 4, 1), 1, 1, 0);
        pin("nominal", 4, 1, 0);
        send(mkp(3, 13, 2, 1), 1, 1, 0);
        pin("short", 0, 0, 1);
        send(mkp(8, 13, 2, 9), 1, 1, 0);
        pin("eight", 2, 9, 0);
        send(mkp(4, 13, 1, 6), 1, 1, 0);
        pin("min", 1, 6, 0);
        send(mkp(16, 13, 2, 1), 1, 1, 0);
        pin("long", 0, 0, 1);
        q = {4'h5, 4'h5, 4'h7, 4'h5, 4'hD, 4'h1};
        send(q, 1, 1, 0);
        pin("bad", 0, 0, 1);
        send(mkp(5, 13, 0, 0), 1, 1, 0);
        pin("empty", 0, 0, 0);
        send(mkp(2, -1, 0, 0), 1, 1, 0);
        pin("trunc", 0, 0, 1);
        q = {4'h5, 4'h5, 4'hD, 4'hA, 4'hB};
        send(q, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("bypass_count", outs.size(), 5);
        for (int i = 0; i < 5; i++) chk("bypass_data", i < outs.size() ? int'(outs[i]) : -1, int'(q[i]));
        chk("bypass_errs", errs, 0);
        outs.delete();
        errs = 0;
        send(mkp(15, 13, 4, 1), 1, 1, 1);
        pin("ce_half", 4, 1, 0);
        q = mkp(4, 13, 1, 1);
        foreach (q[i]) step(1, 0, 1, 1, q[i]);
        step(1, 1, 1, 1, 2);
        step(1, 0, 1, 1, 3);
        step(1, 0, 1, 1, 4);
        step(1, 0, 0, 1, 0);
        pin("rst_mid", 1, 1, 0);
        send(mkp(6, 13, 3, 7), 1, 1, 0);
        pin("after_rst", 3, 7, 0);
        for (int k = 0; k < 60; k++) begin
            int sfd;
            sfd = $urandom_range(0, 7) == 0 ? -1 : ($urandom_range(0, 4) == 0 ? int'($urandom_range(0, 15)) : 13);
            send(mkp($urandom_range(0, 17), sfd, $urandom_range(0, 6), $urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) step(1, 0, 0, 1'($urandom_range(0, 1)), 0);
            outs.delete();
            errs = 0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
